bios_upload_ctrl: RTL and testbench

Writer side of the BIOS ROM upload port. Takes the MiSTer OSD byte-wide file download stream (ioctl_*), packs bytes into 16-bit words, and drives the BIOS RAM upload interface: upload_wr_req, upload_addr[13:1], upload_data, upload_bytesel. The BIOS RAM gives upload priority over CPU reads, so this block also holds the CPU off the bus for the whole transfer.

---
 rtl/bios_upload_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bios_upload_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bios_upload_ctrl.sv
// BIOS ROM upload writer: packs the OSD byte download stream into 16-bit BIOS RAM
// writes and holds the CPU off the bus while a transfer runs. Optional macro: BIOS_UPLOAD_CHECKSUM_EN.
module bios_upload_ctrl #(
  parameter logic [7:0] BIOS_INDEX = 8'd0,
  parameter int         ADDR_WIDTH = 13,
  parameter int         MAX_BYTES  = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  output logic                  upload_wr_req,
  output logic [ADDR_WIDTH:1]   upload_addr,
  output logic [15:0]           upload_data,
  output logic [1:0]            upload_bytesel,
  output logic                  cpu_hold,
  output logic                  upload_done,
  output logic                  upload_overflow,
  output logic [15:0]           upload_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

  localparam logic [24:0] MAX_ADDR = 25'(MAX_BYTES);

  state_t              state, state_next;
  logic                pending;
  logic [7:0]          lo_byte;
  logic [ADDR_WIDTH:1] pend_addr;
  logic                defer_valid;
  logic [7:0]          defer_byte;
  logic [ADDR_WIDTH:1] defer_addr;

  logic                active;
  logic                wr_seen;
  logic                byte_accept;
  logic                odd;
  logic [ADDR_WIDTH:1] waddr;
  logic                pend_match;

  logic                issue;
  logic [ADDR_WIDTH:1] issue_addr;
  logic [15:0]         issue_data;
  logic [1:0]          issue_sel;

  assign active      = ioctl_download && (ioctl_index == BIOS_INDEX);
  assign wr_seen     = (state == S_ACTIVE) && !defer_valid && ioctl_wr && ioctl_download;
  assign byte_accept = wr_seen && (ioctl_addr < MAX_ADDR);
  assign odd         = ioctl_addr[0];
  assign waddr       = ioctl_addr[ADDR_WIDTH:1];
  assign pend_match  = pending && (pend_addr == waddr);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    ioctl_wait = 1'b0;
    case (state)
      S_IDLE: begin
        ioctl_wait = active;
        if (active) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        ioctl_wait = defer_valid;
        // A deferred high byte must go out before the transfer can wind down.
        if (!defer_valid && !ioctl_download) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        ioctl_wait = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        ioctl_wait = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Write selection; the default is a low-byte flush of the pending byte.
  always_comb begin
    issue      = 1'b0;
    issue_addr = pend_addr;
    issue_data = {8'h00, lo_byte};
    issue_sel  = 2'b01;
    if (state == S_ACTIVE && defer_valid) begin
      issue      = 1'b1;
      issue_addr = defer_addr;
      issue_data = {defer_byte, 8'h00};
      issue_sel  = 2'b10;
    end else if (byte_accept) begin
      if (odd && pend_match) begin
        issue      = 1'b1;
        issue_addr = waddr;
        issue_data = {ioctl_dout, lo_byte};
        issue_sel  = 2'b11;
      end else if (pending && !pend_match) begin
        issue = 1'b1;
      end else if (odd) begin
        issue      = 1'b1;
        issue_addr = waddr;
        issue_data = {ioctl_dout, 8'h00};
        issue_sel  = 2'b10;
      end
    end else if (state == S_FLUSH && pending) begin
      issue = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      upload_wr_req   <= 1'b0;
      upload_addr     <= '0;
      upload_data     <= '0;
      upload_bytesel  <= '0;
      cpu_hold        <= 1'b0;
      upload_done     <= 1'b0;
      upload_overflow <= 1'b0;
      pending         <= 1'b0;
      lo_byte         <= '0;
      pend_addr       <= '0;
      defer_valid     <= 1'b0;
      defer_byte      <= '0;
      defer_addr      <= '0;
    end else begin
      upload_wr_req <= issue;
      if (issue) begin
        upload_addr    <= issue_addr;
        upload_data    <= issue_data;
        upload_bytesel <= issue_sel;
      end
      case (state)
        S_IDLE: begin
          if (active) begin
            cpu_hold        <= 1'b1;
            upload_done     <= 1'b0;
            upload_overflow <= 1'b0;
            pending         <= 1'b0;
            defer_valid     <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (defer_valid) begin
            defer_valid <= 1'b0;
          end else if (wr_seen && !byte_accept) begin
            upload_overflow <= 1'b1;
          end else if (byte_accept) begin
            if (!odd) begin
              lo_byte   <= ioctl_dout;
              pend_addr <= waddr;
              pending   <= 1'b1;
            end else if (pend_match) begin
              pending <= 1'b0;
            end else if (pending) begin
              // Flush goes out now; the high byte follows next cycle under ioctl_wait.
              defer_valid <= 1'b1;
              defer_byte  <= ioctl_dout;
              defer_addr  <= waddr;
              pending     <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          pending     <= 1'b0;
          upload_done <= 1'b1;
        end
        S_DONE: cpu_hold <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef BIOS_UPLOAD_CHECKSUM_EN
  logic [15:0] checksum;

  always_ff @(posedge clk) begin
    if (reset)                          checksum <= '0;
    else if (state == S_IDLE && active) checksum <= '0;
    else if (byte_accept)               checksum <= checksum + 16'(ioctl_dout);
  end

  assign upload_checksum = checksum;
`else
  assign upload_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_bios_upload_ctrl.sv
// Scoreboard bench for bios_upload_ctrl: directed downloads push expected BIOS RAM
// writes into a queue that a negedge monitor pops and compares.
module tb_bios_upload_ctrl;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
  } wr_t;

`ifdef BIOS_UPLOAD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        upload_wr_req;
  logic [12:0] upload_addr;
  logic [15:0] upload_data;
  logic [1:0]  upload_bytesel;
  logic        cpu_hold;
  logic        upload_done;
  logic        upload_overflow;
  logic [15:0] upload_checksum;

  int n_checks = 0;
  int n_pass   = 0;
  wr_t exp_q[$];

  bios_upload_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ioctl_download  (ioctl_download),
    .ioctl_index     (ioctl_index),
    .ioctl_wr        (ioctl_wr),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_wait      (ioctl_wait),
    .upload_wr_req   (upload_wr_req),
    .upload_addr     (upload_addr),
    .upload_data     (upload_data),
    .upload_bytesel  (upload_bytesel),
    .cpu_hold        (cpu_hold),
    .upload_done     (upload_done),
    .upload_overflow (upload_overflow),
    .upload_checksum (upload_checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [12:0] a, input logic [15:0] d, input logic [1:0] s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.sel  = s;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ioctl_wait_bound", {31'd0, ioctl_wait}, 32'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    repeat (4) tick();
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && upload_wr_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {19'd0, upload_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr",    {19'd0, upload_addr},    {19'd0, w.addr});
        check("wr_data",    {16'd0, upload_data},    {16'd0, w.data});
        check("wr_bytesel", {30'd0, upload_bytesel}, {30'd0, w.sel});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (2) tick();
    check("rst_wr_req",   {31'd0, upload_wr_req},   32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold},        32'd0);
    check("rst_done",     {31'd0, upload_done},     32'd0);
    check("rst_overflow", {31'd0, upload_overflow}, 32'd0);
    check("rst_checksum", {16'd0, upload_checksum}, 32'd0);
    reset = 1'b0;
    tick();

    // Two-byte file packs into one full-word write.
    start_dl(8'd0);
    check("t1_cpu_hold_start", {31'd0, cpu_hold}, 32'd1);
    send_byte(25'd0, 8'h55);
    push(13'd0, 16'hAA55, 2'b11);
    send_byte(25'd1, 8'hAA);
    end_dl();
    check("t1_done",     {31'd0, upload_done}, 32'd1);
    check("t1_cpu_hold", {31'd0, cpu_hold},    32'd0);
    check("t1_checksum", {16'd0, upload_checksum}, CSUM ? 32'h00FF : 32'd0);

    // Odd-length file: trailing byte flushed after download falls.
    start_dl(8'd0);
    check("t2_done_cleared", {31'd0, upload_done}, 32'd0);
    push(13'd0, 16'h2211, 2'b11);
    push(13'd1, 16'h0033, 2'b01);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    ioctl_download = 1'b0;
    tick();
    tick();
    check("t2_cpu_hold_in_done", {31'd0, cpu_hold},    32'd1);
    check("t2_done_in_done",     {31'd0, upload_done}, 32'd1);
    tick();
    check("t2_cpu_hold_dropped", {31'd0, cpu_hold}, 32'd0);
    check("t2_checksum", {16'd0, upload_checksum}, CSUM ? 32'h0066 : 32'd0);
    repeat (2) tick();

    // Non-matching odd byte splits into a flush plus a deferred high-byte write.
    start_dl(8'd0);
    push(13'd2, 16'h005A, 2'b01);
    push(13'd3, 16'hC300, 2'b10);
    send_byte(25'd4, 8'h5A);
    send_byte(25'd7, 8'hC3);
    check("t3_wait_split", {31'd0, ioctl_wait}, 32'd1);
    tick();
    check("t3_wait_released", {31'd0, ioctl_wait}, 32'd0);
    end_dl();

    // Byte past capacity is dropped and flagged.
    start_dl(8'd0);
    check("t4_overflow_cleared", {31'd0, upload_overflow}, 32'd0);
    push(13'd0, 16'h0201, 2'b11);
    send_byte(25'd0, 8'h01);
    send_byte(25'd1, 8'h02);
    send_byte(25'd16384, 8'h77);
    check("t4_overflow",  {31'd0, upload_overflow}, 32'd1);
    check("t4_checksum",  {16'd0, upload_checksum}, CSUM ? 32'h0003 : 32'd0);
    end_dl();
    check("t4_overflow_held", {31'd0, upload_overflow}, 32'd1);
    check("t4_done",          {31'd0, upload_done},     32'd1);

    // Other file index is ignored entirely.
    start_dl(8'd3);
    send_byte(25'd0, 8'hDE);
    send_byte(25'd1, 8'hAD);
    check("t5_cpu_hold", {31'd0, cpu_hold},   32'd0);
    check("t5_wait",     {31'd0, ioctl_wait}, 32'd0);
    end_dl();
    check("t5_done_unchanged",     {31'd0, upload_done},     32'd1);
    check("t5_overflow_unchanged", {31'd0, upload_overflow}, 32'd1);

    // Reset mid-transfer aborts; a fresh download then completes.
    start_dl(8'd0);
    send_byte(25'd0, 8'h99);
    reset = 1'b1;
    tick();
    check("t6_rst_cpu_hold", {31'd0, cpu_hold},        32'd0);
    check("t6_rst_done",     {31'd0, upload_done},     32'd0);
    check("t6_rst_overflow", {31'd0, upload_overflow}, 32'd0);
    check("t6_rst_data",     {16'd0, upload_data},     32'd0);
    reset          = 1'b0;
    ioctl_download = 1'b0;
    tick();
    start_dl(8'd0);
    push(13'd0, 16'h2010, 2'b11);
    send_byte(25'd0, 8'h10);
    send_byte(25'd1, 8'h20);
    end_dl();
    check("t6_done",     {31'd0, upload_done}, 32'd1);
    check("t6_cpu_hold", {31'd0, cpu_hold},    32'd0);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
